apb_periph_completer: RTL

//  APB-style completer (responder) at the far end of the CPU's peripheral bus.

---
 rtl/apb_periph_pkg.sv | 17 +
 rtl/apb_periph_if.sv | 24 ++
 rtl/apb_periph_regfile.sv | 38 +++
 rtl/apb_periph_completer.sv | 119 +++++++++++
 4 files changed

// File: rtl/apb_periph_pkg.sv
// Shared types and widths for the APB peripheral completer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_periph_pkg;

  typedef enum logic {IDLE, ACCESS} periph_state_t;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 21;
  localparam int WRCOUNT_W  = 16;

  // Index width for a register file of n entries; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_periph_if.sv
// CPU peripheral bus bundle: select, enable, address/data and the completer response.
// Latency: n/a (wires only).
// Backpressure: the completer stretches a transfer by holding CPUPREADY low.
interface apb_periph_if;
  import apb_periph_pkg::*;

  logic [7:0]            CPUSEL;
  logic                  APBMASTERENABLE;
  logic [CPU_ADDR_W-1:0] addr;
  logic [CPU_DATA_W-1:0] data;
  logic                  CPUPREADY;
  logic                  PSLVERR;

  modport master (
    output CPUSEL, APBMASTERENABLE, addr, data,
    input  CPUPREADY, PSLVERR
  );

  modport slave (
    input  CPUSEL, APBMASTERENABLE, addr, data,
    output CPUPREADY, PSLVERR
  );

endinterface

// File: rtl/apb_periph_regfile.sv
// Register file: one synchronous write port, one combinational read port, sync clear.
// Latency: write visible on the read port after the clock edge; read is same-cycle.
// Backpressure: none, accepts a write every cycle.
module apb_periph_regfile #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 21,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rdaddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] NUM_LIM = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Clear everything on reset, otherwise commit the single write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[idx] <= wdata;
    end
  end

  // Side read port; addresses past the end read back as zero.
  always_comb begin
    rdata = '0;
    if ({1'b0, rdaddr} < NUM_LIM) rdata = regs[rdaddr[IDX_W-1:0]];
  end

endmodule

// File: rtl/apb_periph_completer.sv
// APB-style write-only completer: decode select, latch setup, wait, pulse CPUPREADY, commit.
// Latency: CPUPREADY in cycle T0+1+WAIT_STATES after setup at T0 with enable held high.
// Backpressure: inserts WAIT_STATES wait cycles; enable low in access holds the counter.
// Optional: define APB_PERIPH_PSLVERR_EN to flag out-of-range writes on PSLVERR.
module apb_periph_completer
  import apb_periph_pkg::*;
#(
  parameter int SEL_INDEX   = 0,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 3,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int ADDR_W      = CPU_ADDR_W
) (
  input  logic                 clk,
  input  logic                 CPUPERPHRESETN,
  apb_periph_if.slave          bus,
  input  logic [ADDR_W-1:0]    RDADDR,
  output logic [DATA_W-1:0]    RDDATA,
  output logic [WRCOUNT_W-1:0] WRCOUNT
);

  localparam int              IDX_W    = idx_width(NUM_REGS);
  localparam int              CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W:0]  NUM_LIM  = (ADDR_W+1)'(NUM_REGS);

  periph_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pready;
  logic              in_range;
  logic              commit;

  logic sel;
  logic en;
  assign sel = bus.CPUSEL[SEL_INDEX];
  assign en  = bus.APBMASTERENABLE;

  // Decode uses the latched address so bus changes during access are ignored.
  assign in_range = ({1'b0, addr_q} < NUM_LIM);
  assign commit   = pready && in_range;

  // Next state: latch on setup, count waits, complete or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && !en) begin
          state_d = ACCESS;
          cnt_d   = '0;
          addr_d  = bus.addr;
          data_d  = bus.data;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (en) begin
          if (cnt_q == WAIT_CNT) begin
            pready  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!CPUPERPHRESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Count committed in-range writes, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!CPUPERPHRESETN) WRCOUNT <= '0;
    else if (commit && (WRCOUNT != {WRCOUNT_W{1'b1}})) WRCOUNT <= WRCOUNT + 1'b1;
  end

  assign bus.CPUPREADY = pready;
`ifdef APB_PERIPH_PSLVERR_EN
  assign bus.PSLVERR = pready && !in_range;
`else
  assign bus.PSLVERR = 1'b0;
`endif

  apb_periph_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .clr    (!CPUPERPHRESETN),
    .we     (commit),
    .idx    (addr_q[IDX_W-1:0]),
    .wdata  (data_q),
    .rdaddr (RDADDR),
    .rdata  (RDDATA)
  );

endmodule
